// File: rtl/nd_rr_arb4_pkg.sv
// Shared definitions for the four-input round-robin message concentrator.
// Holds the default message field sizes, the port index type and the
// rotating-priority pick helper used by the top-level arbiter.
package nd_rr_arb4_pkg;

  localparam int unsigned NS_MESSAGE_FIFO_SIZE = 4;
  localparam int unsigned NS_ADDRESS_SIZE      = 8;
  localparam int unsigned NS_DATA_SIZE         = 8;
  localparam int unsigned NS_REDUN_SIZE        = 4;

  localparam int unsigned NumPorts = 4;

  typedef logic [1:0] port_idx_t;

  typedef struct packed {
    logic      valid;
    port_idx_t idx;
  } grant_t;

  // First set bit of elig found scanning ptr, ptr+1, ... modulo 4.
  function automatic grant_t rr_pick(input logic [NumPorts-1:0] elig, input port_idx_t ptr);
    grant_t    g;
    port_idx_t n;
    g = '0;
    // Scan from the far end back toward ptr so the last hit is the nearest one.
    for (int k = NumPorts - 1; k >= 0; k--) begin
      n = ptr + port_idx_t'(k);
      if (elig[n]) begin
        g.valid = 1'b1;
        g.idx   = n;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/nd_msg_fifo.sv
// Message FIFO for the concentrator: FSZ entries of {addr, data, red}.
// Ports:
//   i_clk, reset            clock and asynchronous active-high reset
//   i_push, i_push_*        write one message (ignored when full)
//   i_pop                   drop the tail message (ignored when empty)
//   o_tail_*                oldest buffered message
//   o_full, o_empty         occupancy flags from the registered count
module nd_msg_fifo
  import nd_rr_arb4_pkg::*;
#(
  parameter int unsigned FSZ = NS_MESSAGE_FIFO_SIZE,
  parameter int unsigned ASZ = NS_ADDRESS_SIZE,
  parameter int unsigned DSZ = NS_DATA_SIZE,
  parameter int unsigned RSZ = NS_REDUN_SIZE
) (
  input  logic           i_clk,
  input  logic           reset,
  input  logic           i_push,
  input  logic [ASZ-1:0] i_push_addr,
  input  logic [DSZ-1:0] i_push_data,
  input  logic [RSZ-1:0] i_push_red,
  input  logic           i_pop,
  output logic [ASZ-1:0] o_tail_addr,
  output logic [DSZ-1:0] o_tail_data,
  output logic [RSZ-1:0] o_tail_red,
  output logic           o_full,
  output logic           o_empty
);

  localparam int unsigned PW = $clog2(FSZ);
  localparam int unsigned MW = ASZ + DSZ + RSZ;

  localparam logic [PW:0]   FullCnt = FSZ[PW:0];
  localparam logic [PW:0]   CntOne  = 1;
  localparam logic [PW-1:0] PtrOne  = 1;

  logic [MW-1:0] r_mem [FSZ];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [PW:0]   r_cnt;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_cnt == FullCnt);
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  assign {o_tail_addr, o_tail_data, o_tail_red} = r_mem[r_rd];

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PtrOne;
      if (w_pop)  r_rd <= r_rd + PtrOne;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CntOne;
        2'b01:   r_cnt <= r_cnt - CntOne;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage needs no reset: a zero count hides whatever it still holds.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= {i_push_addr, i_push_data, i_push_red};
  end

endmodule

// File: rtl/nd_rr_arb4.sv
// Four-input, one-output message concentrator. Four inbound four-phase
// channels are granted round-robin into a message FIFO that is replayed on
// one outbound four-phase channel.
// Ports:
//   i_clk, reset                     clock, asynchronous active-high reset
//   ready                            high after the post-reset init cycle
//   rcvN_addr/data/red/req, rcvN_ack inbound channels N = 0..3
//   snd0_addr/data/red/req, snd0_ack outbound channel (fields registered)
module nd_rr_arb4
  import nd_rr_arb4_pkg::*;
#(
  parameter int unsigned FSZ = NS_MESSAGE_FIFO_SIZE,
  parameter int unsigned ASZ = NS_ADDRESS_SIZE,
  parameter int unsigned DSZ = NS_DATA_SIZE,
  parameter int unsigned RSZ = NS_REDUN_SIZE
) (
  input  logic           i_clk,
  input  logic           reset,
  output logic           ready,
  input  logic [ASZ-1:0] rcv0_addr,
  input  logic [DSZ-1:0] rcv0_data,
  input  logic [RSZ-1:0] rcv0_red,
  input  logic           rcv0_req,
  output logic           rcv0_ack,
  input  logic [ASZ-1:0] rcv1_addr,
  input  logic [DSZ-1:0] rcv1_data,
  input  logic [RSZ-1:0] rcv1_red,
  input  logic           rcv1_req,
  output logic           rcv1_ack,
  input  logic [ASZ-1:0] rcv2_addr,
  input  logic [DSZ-1:0] rcv2_data,
  input  logic [RSZ-1:0] rcv2_red,
  input  logic           rcv2_req,
  output logic           rcv2_ack,
  input  logic [ASZ-1:0] rcv3_addr,
  input  logic [DSZ-1:0] rcv3_data,
  input  logic [RSZ-1:0] rcv3_red,
  input  logic           rcv3_req,
  output logic           rcv3_ack,
  output logic [ASZ-1:0] snd0_addr,
  output logic [DSZ-1:0] snd0_data,
  output logic [RSZ-1:0] snd0_red,
  output logic           snd0_req,
  input  logic           snd0_ack
);

  logic                r_ready;
  logic [NumPorts-1:0] r_ack;
  port_idx_t           r_ptr;
  logic                r_snd_req;
  logic [ASZ-1:0]      r_snd_addr;
  logic [DSZ-1:0]      r_snd_data;
  logic [RSZ-1:0]      r_snd_red;

  logic [NumPorts-1:0] w_req;
  logic [NumPorts-1:0] w_elig;
  logic [NumPorts-1:0] w_release;
  logic [NumPorts-1:0] w_grant_oh;
  grant_t              w_pick;
  logic                w_grant;
  logic                w_load;
  logic                w_full;
  logic                w_empty;
  logic [ASZ-1:0]      w_win_addr;
  logic [DSZ-1:0]      w_win_data;
  logic [RSZ-1:0]      w_win_red;
  logic [ASZ-1:0]      w_tail_addr;
  logic [DSZ-1:0]      w_tail_data;
  logic [RSZ-1:0]      w_tail_red;

  assign w_req     = {rcv3_req, rcv2_req, rcv1_req, rcv0_req};
  assign w_elig    = w_req & ~r_ack;
  assign w_release = ~w_req & r_ack;
  assign w_pick    = rr_pick(w_elig, r_ptr);

  // Both decisions use the pre-edge FIFO flags, so a pop never frees room
  // for a push at the same edge and a fresh push is never loaded at once.
  assign w_grant    = r_ready & w_pick.valid & ~w_full;
  assign w_load     = r_ready & ~r_snd_req & ~snd0_ack & ~w_empty;
  assign w_grant_oh = w_grant ? (4'b0001 << w_pick.idx) : 4'b0000;

  always_comb begin
    w_win_addr = rcv0_addr;
    w_win_data = rcv0_data;
    w_win_red  = rcv0_red;
    unique case (w_pick.idx)
      2'd0: begin
        w_win_addr = rcv0_addr;
        w_win_data = rcv0_data;
        w_win_red  = rcv0_red;
      end
      2'd1: begin
        w_win_addr = rcv1_addr;
        w_win_data = rcv1_data;
        w_win_red  = rcv1_red;
      end
      2'd2: begin
        w_win_addr = rcv2_addr;
        w_win_data = rcv2_data;
        w_win_red  = rcv2_red;
      end
      2'd3: begin
        w_win_addr = rcv3_addr;
        w_win_data = rcv3_data;
        w_win_red  = rcv3_red;
      end
    endcase
  end

  nd_msg_fifo #(
    .FSZ(FSZ),
    .ASZ(ASZ),
    .DSZ(DSZ),
    .RSZ(RSZ)
  ) u_fifo (
    .i_clk       (i_clk),
    .reset       (reset),
    .i_push      (w_grant),
    .i_push_addr (w_win_addr),
    .i_push_data (w_win_data),
    .i_push_red  (w_win_red),
    .i_pop       (w_load),
    .o_tail_addr (w_tail_addr),
    .o_tail_data (w_tail_data),
    .o_tail_red  (w_tail_red),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      r_ready    <= 1'b0;
      r_ack      <= '0;
      r_ptr      <= '0;
      r_snd_req  <= 1'b0;
      r_snd_addr <= '0;
      r_snd_data <= '0;
      r_snd_red  <= '0;
    end else if (!r_ready) begin
      // Init cycle: come up and do nothing else.
      r_ready <= 1'b1;
    end else begin
      r_ack <= (r_ack & ~w_release) | w_grant_oh;
      if (w_grant) r_ptr <= w_pick.idx + 2'd1;
      if (w_load) begin
        r_snd_addr <= w_tail_addr;
        r_snd_data <= w_tail_data;
        r_snd_red  <= w_tail_red;
        r_snd_req  <= 1'b1;
      end else if (r_snd_req && snd0_ack) begin
        r_snd_req <= 1'b0;
      end
    end
  end

  assign ready     = r_ready;
  assign rcv0_ack  = r_ack[0];
  assign rcv1_ack  = r_ack[1];
  assign rcv2_ack  = r_ack[2];
  assign rcv3_ack  = r_ack[3];
  assign snd0_req  = r_snd_req;
  assign snd0_addr = r_snd_addr;
  assign snd0_data = r_snd_data;
  assign snd0_red  = r_snd_red;

endmodule

// File: tb/tb_nd_rr_arb4.sv
// Bench for nd_rr_arb4: behavioural producers/consumer, a queue-based
// reference model checked every cycle, and directed literal expectations.
module tb_nd_rr_arb4;

  localparam int FSZ = 4;
  localparam int ASZ = 8;
  localparam int DSZ = 8;
  localparam int RSZ = 4;

  typedef logic [ASZ+DSZ+RSZ-1:0] msg_t;

  logic           i_clk;
  logic           reset;
  logic           ready;
  logic [ASZ-1:0] rcv_addr [4];
  logic [DSZ-1:0] rcv_data [4];
  logic [RSZ-1:0] rcv_red  [4];
  logic [3:0]     rcv_req;
  logic [3:0]     rcv_ack;
  logic [ASZ-1:0] snd0_addr;
  logic [DSZ-1:0] snd0_data;
  logic [RSZ-1:0] snd0_red;
  logic           snd0_req;
  logic           snd0_ack;

  nd_rr_arb4 #(
    .FSZ(FSZ),
    .ASZ(ASZ),
    .DSZ(DSZ),
    .RSZ(RSZ)
  ) dut (
    .i_clk     (i_clk),
    .reset     (reset),
    .ready     (ready),
    .rcv0_addr (rcv_addr[0]),
    .rcv0_data (rcv_data[0]),
    .rcv0_red  (rcv_red[0]),
    .rcv0_req  (rcv_req[0]),
    .rcv0_ack  (rcv_ack[0]),
    .rcv1_addr (rcv_addr[1]),
    .rcv1_data (rcv_data[1]),
    .rcv1_red  (rcv_red[1]),
    .rcv1_req  (rcv_req[1]),
    .rcv1_ack  (rcv_ack[1]),
    .rcv2_addr (rcv_addr[2]),
    .rcv2_data (rcv_data[2]),
    .rcv2_red  (rcv_red[2]),
    .rcv2_req  (rcv_req[2]),
    .rcv2_ack  (rcv_ack[2]),
    .rcv3_addr (rcv_addr[3]),
    .rcv3_data (rcv_data[3]),
    .rcv3_red  (rcv_red[3]),
    .rcv3_req  (rcv_req[3]),
    .rcv3_ack  (rcv_ack[3]),
    .snd0_addr (snd0_addr),
    .snd0_data (snd0_data),
    .snd0_red  (snd0_red),
    .snd0_req  (snd0_req),
    .snd0_ack  (snd0_ack)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus state
  msg_t pq [4][$];
  bit   auto_ack = 1'b1;
  logic [7:0] out_log [$];

  // Producers and consumer act 2 time units after each rising edge.
  initial begin
    msg_t m;
    forever begin
      @(posedge i_clk);
      #2;
      if (!reset) begin
        for (int n = 0; n < 4; n++) begin
          if (rcv_req[n] && rcv_ack[n]) begin
            rcv_req[n] = 1'b0;
          end else if (!rcv_req[n] && !rcv_ack[n] && pq[n].size() > 0) begin
            m = pq[n].pop_front();
            {rcv_addr[n], rcv_data[n], rcv_red[n]} = m;
            rcv_req[n] = 1'b1;
          end
        end
        if (auto_ack) begin
          if (snd0_req && !snd0_ack) snd0_ack = 1'b1;
          else if (!snd0_req && snd0_ack) snd0_ack = 1'b0;
        end
      end
    end
  end

  // Reference model: message queue plus handshake bits, stepped per edge.
  msg_t     m_q [$];
  bit       m_ready = 1'b0;
  bit [3:0] m_ack = 4'b0;
  int       m_ptr = 0;
  bit       m_sreq = 1'b0;
  msg_t     m_smsg = '0;

  initial begin
    int  w;
    int  n;
    bit  full;
    bit  empty;
    forever begin
      @(posedge i_clk or posedge reset);
      if (reset) begin
        m_q.delete();
        m_ready = 1'b0;
        m_ack   = 4'b0;
        m_ptr   = 0;
        m_sreq  = 1'b0;
        m_smsg  = '0;
      end else if (!m_ready) begin
        m_ready = 1'b1;
      end else begin
        full  = (m_q.size() == FSZ);
        empty = (m_q.size() == 0);
        w = -1;
        if (!full) begin
          for (int k = 0; k < 4; k++) begin
            n = (m_ptr + k) % 4;
            if (w < 0 && rcv_req[n] && !m_ack[n]) w = n;
          end
        end
        if (!m_sreq && !snd0_ack && !empty) begin
          m_smsg = m_q.pop_front();
          m_sreq = 1'b1;
        end else if (m_sreq && snd0_ack) begin
          m_sreq = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin
          if (!rcv_req[k] && m_ack[k]) m_ack[k] = 1'b0;
        end
        if (w >= 0) begin
          m_q.push_back({rcv_addr[w], rcv_data[w], rcv_red[w]});
          m_ack[w] = 1'b1;
          m_ptr = (w + 1) % 4;
        end
      end
    end
  end

  // Per-cycle compare against the model, plus output-order logging.
  initial begin
    bit prev_req = 1'b0;
    forever begin
      @(negedge i_clk);
      check("m_ready", 32'(ready), 32'(m_ready));
      check("m_acks", 32'(rcv_ack), 32'(m_ack));
      check("m_snd_req", 32'(snd0_req), 32'(m_sreq));
      check("m_snd_addr", 32'(snd0_addr), 32'(m_smsg[19:12]));
      check("m_snd_data", 32'(snd0_data), 32'(m_smsg[11:4]));
      check("m_snd_red", 32'(snd0_red), 32'(m_smsg[3:0]));
      if (snd0_req && !prev_req) out_log.push_back(snd0_data);
      prev_req = snd0_req;
    end
  end

  task automatic clear_stim();
    for (int n = 0; n < 4; n++) pq[n].delete();
    rcv_req  = 4'b0;
    snd0_ack = 1'b0;
  endtask

  task automatic reset_pulse();
    @(posedge i_clk);
    #2;
    reset = 1'b1;
    clear_stim();
    @(posedge i_clk);
    #2;
    reset = 1'b0;
    out_log.delete();
    @(negedge i_clk);
    check("ready_before_edge", 32'(ready), 32'd0);
    @(negedge i_clk);
    check("ready_after_edge", 32'(ready), 32'd1);
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    bit ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge i_clk);
      if (pq[0].size() == 0 && pq[1].size() == 0 && pq[2].size() == 0 &&
          pq[3].size() == 0 && rcv_req == 4'b0 && rcv_ack == 4'b0 &&
          !snd0_req && !snd0_ack && m_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_idle_timeout"}, 32'(ok), 32'd1);
  endtask

  task automatic check_log(input string name, input logic [7:0] exp [$]);
    check({name, "_count"}, 32'(out_log.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i < out_log.size()) check({name, "_data"}, 32'(out_log[i]), 32'(exp[i]));
    end
  endtask

  task automatic wait_req(input string name, input logic level, input int max_cyc);
    bit ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge i_clk);
      if (snd0_req == level) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_timeout"}, 32'(ok), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ex [$];
    reset = 1'b1;
    rcv_req = 4'b0;
    snd0_ack = 1'b0;
    for (int n = 0; n < 4; n++) begin
      rcv_addr[n] = '0;
      rcv_data[n] = '0;
      rcv_red[n]  = '0;
    end
    repeat (2) @(negedge i_clk);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_acks", 32'(rcv_ack), 32'd0);
    check("rst_snd_req", 32'(snd0_req), 32'd0);
    check("rst_snd_data", 32'(snd0_data), 32'd0);
    @(posedge i_clk);
    #2;
    reset = 1'b0;
    @(negedge i_clk);
    check("init_ready_low", 32'(ready), 32'd0);
    @(negedge i_clk);
    check("init_ready_high", 32'(ready), 32'd1);

    // Basic pass-through on rcv2
    auto_ack = 1'b1;
    @(negedge i_clk);
    pq[2].push_back({8'h05, 8'hA5, 4'h2});
    @(posedge i_clk);
    @(negedge i_clk);
    check("pt_ack_not_yet", 32'(rcv_ack[2]), 32'd0);
    @(negedge i_clk);
    check("pt_ack", 32'(rcv_ack[2]), 32'd1);
    check("pt_req_not_yet", 32'(snd0_req), 32'd0);
    @(negedge i_clk);
    check("pt_snd_req", 32'(snd0_req), 32'd1);
    check("pt_snd_addr", 32'(snd0_addr), 32'h05);
    check("pt_snd_data", 32'(snd0_data), 32'hA5);
    wait_idle("pt", 40);
    check("pt_req_done", 32'(snd0_req), 32'd0);

    // Round-robin with all four inputs
    reset_pulse();
    auto_ack = 1'b1;
    @(negedge i_clk);
    for (int r = 0; r < 2; r++)
      for (int n = 0; n < 4; n++)
        pq[n].push_back({8'(8'h80 + n), 8'(8'h10 + n), 4'(n)});
    wait_idle("rr", 300);
    ex.delete();
    for (int i = 0; i < 8; i++) ex.push_back(8'(8'h10 + i % 4));
    check_log("rr", ex);

    // Full FIFO, then simultaneous pop and blocked push at full
    reset_pulse();
    auto_ack = 1'b0;
    @(negedge i_clk);
    for (int i = 0; i < 6; i++) pq[0].push_back({8'h01, 8'(8'h20 + i), 4'(i)});
    repeat (25) @(negedge i_clk);
    check("full_snd_req", 32'(snd0_req), 32'd1);
    check("full_snd_data", 32'(snd0_data), 32'h20);
    check("full_no_ack", 32'(rcv_ack[0]), 32'd0);
    repeat (3) @(negedge i_clk);
    check("full_still_no_ack", 32'(rcv_ack[0]), 32'd0);
    auto_ack = 1'b1;
    wait_req("full_release", 1'b0, 10);
    wait_req("full_reload", 1'b1, 10);
    check("full_no_grant_at_pop", 32'(rcv_ack[0]), 32'd0);
    check("full_reload_data", 32'(snd0_data), 32'h21);
    @(negedge i_clk);
    check("full_grant_after_pop", 32'(rcv_ack[0]), 32'd1);
    wait_idle("full", 200);
    ex.delete();
    for (int i = 0; i < 6; i++) ex.push_back(8'(8'h20 + i));
    check_log("full", ex);

    // Pointer wrap with rcv3 and rcv0
    reset_pulse();
    auto_ack = 1'b1;
    @(negedge i_clk);
    pq[3].push_back({8'h03, 8'h33, 4'h3});
    pq[3].push_back({8'h03, 8'h33, 4'h3});
    @(negedge i_clk);
    pq[0].push_back({8'h00, 8'h30, 4'h0});
    pq[0].push_back({8'h00, 8'h30, 4'h0});
    wait_idle("wrap", 200);
    ex.delete();
    ex.push_back(8'h33);
    ex.push_back(8'h30);
    ex.push_back(8'h33);
    ex.push_back(8'h30);
    check_log("wrap", ex);

    // Reset mid-operation
    reset_pulse();
    auto_ack = 1'b0;
    @(negedge i_clk);
    for (int i = 0; i < 3; i++) pq[1].push_back({8'h11, 8'(8'h40 + i), 4'(i)});
    repeat (12) @(negedge i_clk);
    check("mid_snd_req", 32'(snd0_req), 32'd1);
    check("mid_snd_data", 32'(snd0_data), 32'h40);
    #1;
    reset = 1'b1;
    clear_stim();
    #1;
    check("mid_rst_ready", 32'(ready), 32'd0);
    check("mid_rst_snd_req", 32'(snd0_req), 32'd0);
    check("mid_rst_acks", 32'(rcv_ack), 32'd0);
    @(posedge i_clk);
    #3;
    reset = 1'b0;
    out_log.delete();
    @(negedge i_clk);
    check("mid_ready_low", 32'(ready), 32'd0);
    @(negedge i_clk);
    check("mid_ready_high", 32'(ready), 32'd1);
    repeat (4) @(negedge i_clk);
    check("mid_no_stale", 32'(snd0_req), 32'd0);
    auto_ack = 1'b1;
    pq[2].push_back({8'h22, 8'h77, 4'h7});
    wait_idle("mid", 60);
    ex.delete();
    ex.push_back(8'h77);
    check_log("mid", ex);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nd_rr_arb4.md
# nd_rr_arb4

Four-input, one-output message concentrator for the node network. It shares one outbound channel among four inbound four-phase channels using a rotating-priority (round-robin) grant. Granted messages are buffered in an FSZ-entry FIFO and then replayed on the output channel. It sits in front of any node stage that has exactly one input port and must serve up to four upstream producers without starving any of them.

## Interface
- `FSZ`, default `` `NS_MESSAGE_FIFO_SIZE ``: FIFO depth in messages. Must be a power of two and at least 2.
- `ASZ`, default `` `NS_ADDRESS_SIZE ``: width of the message address field.
- `DSZ`, default `` `NS_DATA_SIZE ``: width of the message data field.
- `RSZ`, default `` `NS_REDUN_SIZE ``: width of the message redundancy field.
- `i_clk` in 1: the single clock; everything is on the rising edge.
- `reset` in 1: asynchronous, active-high. Clears all state immediately, independent of `i_clk`.
- `ready` out 1: high once the post-reset init cycle has completed.
- `rcvN_addr` in ASZ, for N=0..3: inbound message address.
- `rcvN_data` in DSZ: inbound message data.
- `rcvN_red` in RSZ: inbound message redundancy field.
- `rcvN_req` in 1: inbound request; the message is stable while this is high.
- `rcvN_ack` out 1: inbound acknowledge.
- `snd0_addr` out ASZ, `snd0_data` out DSZ, `snd0_red` out RSZ: outbound message, driven from registers.
- `snd0_req` out 1: outbound request.
- `snd0_ack` in 1: outbound acknowledge.

## Operation
**Reset values:** `ready`=0, every `rcvN_ack`=0, `snd0_req`=0, `snd0_*` fields=0, priority pointer `ptr`=0, FIFO empty (count=0).

**Init:**
- On the first `i_clk` edge with `reset` low, set `ready`=1 and perform no other action.
- While `ready`=0, ignore all requests and acks.

**Eligibility:** input N is eligible when `rcvN_req`=1 and `rcvN_ack`=0.

**Grant:**
- When the FIFO is not full, the winner is the first eligible input found scanning `ptr`, `ptr+1`, … modulo 4.
- At the edge, push the winner's {addr,data,red} into the FIFO, set `rcvN_ack`=1, and set `ptr` to (winner+1) mod 4.
- At most one grant per cycle.
- If no input is eligible, or the FIFO is full, there is no grant and `ptr` holds.

**Ack release:** when `rcvN_req`=0 and `rcvN_ack`=1, clear `rcvN_ack` at the edge. This is independent per input and may coincide with a grant to another input.

**Output side:**
- Load: when `snd0_req`=0, `snd0_ack`=0 and the FIFO is non-empty, load the FIFO tail into the `snd0_*` registers, set `snd0_req`=1 and pop, all at one edge.
- Release: when `snd0_req`=1 and `snd0_ack`=1, clear `snd0_req`.
- Hold: `snd0_*` fields hold their value until the next load.

**Full/empty decisions:**
- Grant eligibility uses the count before the edge. A full FIFO blocks a push even if a pop happens at the same edge.
- Output load uses the non-empty state before the edge. A message pushed at edge t cannot be loaded before edge t+1.
- A simultaneous push and pop leaves the count unchanged; the pointers wrap modulo FSZ.

**Count arithmetic:** the count is $clog2(FSZ)+1 bits wide. Full is count==FSZ; empty is count==0.

**Reset mid-operation:**
- All buffered and in-flight messages are discarded and all acks and `snd0_req` drop asynchronously.
- Upstream senders re-present their requests after `ready` returns.

## Timing
- `ready` rises at the first clock edge after `reset` deasserts.
- Capture latency: an eligible `rcvN_req` sampled at edge t gives `rcvN_ack`=1 after edge t.
- Input-to-output latency with an empty FIFO and an idle output:
  - capture at edge t;
  - `snd0_req`=1 after edge t+1.
- Output throughput is at most one message per four-phase cycle:
  - load at edge a;
  - `snd0_ack` rises;
  - `snd0_req` drops at the next edge;
  - `snd0_ack` falls;
  - the next load follows at the next edge.
- Fairness: with all four inputs continuously eligible and space available, grants follow 0,1,2,3,0,…. No input waits more than 3 grants.

## Structure
- `NS_ON`/`NS_OFF`, `NS_TRUE`/`NS_FALSE`, size defaults and the channel declaration macros live in the shared `hglobal.v`. Nothing block-specific is added there.
- The FIFO is one sub-module, `nd_msg_fifo`:
  - parameters FSZ, ASZ, DSZ, RSZ;
  - ports push, push data, pop, tail data, full, empty;
  - same asynchronous reset.
- The arbiter scan, the priority pointer and the handshake registers stay in the top module.

## Test plan
- **Basic pass-through:** reset pulse, then `rcv2` sends addr=0x5/data=0xA5. Required: `rcv2_ack`=1 one edge after sampling; `snd0_req` rises one edge later with addr=0x5, data=0xA5; after `snd0_ack` toggles, `snd0_req` returns to 0.
- **Round-robin:** all four inputs request together with data 0x10, 0x11, 0x12, 0x13 and each re-requests immediately after ack release. Required: output data order 0x10, 0x11, 0x12, 0x13, 0x10, …
- **Full FIFO:** FSZ=4, `snd0_ack` held 0, `rcv0` sends 6 messages. Required:
  - message 1 is loaded into `snd0_*`;
  - messages 2–5 fill the FIFO;
  - message 6 sees no ack until `snd0_ack` completes one four-phase cycle, then is acked the cycle after the pop.
- **Simultaneous push and pop at full:** FIFO full with `snd0` releasing at the same edge a new request is eligible. Required: no grant at that edge, grant at the following edge, count stays correct with no loss or duplication.
- **Pointer wrap:** only `rcv3` and `rcv0` request continuously. Required: alternation 3,0,3,0; `ptr` wraps from 3 to 0.
- **Reset mid-operation:** assert `reset` asynchronously, between edges, while `snd0_req`=1 and 2 messages are buffered. Required: `snd0_req`, all acks and `ready` drop immediately; after release, `ready`=1 at the first edge and no stale message appears on `snd0`.
